reg_file_param: RTL and testbench
=================================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of every register and data port (minimum 2).
REQ-002 The block SHALL have parameter NREG, default 8, giving the register count (range 2..16).
REQ-003 The block SHALL have parameter SEL_W, default $clog2(NREG), giving the read-select width.
REQ-004 The block SHALL have parameter OUT_REG, default 0: 0 = combinational read ports, 1 = registered read ports.
REQ-005 The block SHALL have port Clock  input  1  the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port I  input  WIDTH  write/load data.
REQ-008 The block SHALL have port FunSel  input  3  operation applied to every enabled register.
REQ-009 The block SHALL have port RegSel  input  NREG  per-register write enable, active-low; bit NREG-1 = register 0, bit 0 = register NREG-1.
REQ-010 The block SHALL have ports OutASel and OutBSel  input  SEL_W  each selecting the register driven on its read port.
REQ-011 The block SHALL have port ClrFlags  input  1  clears all sticky Wrap flags.
REQ-012 The block SHALL have ports OutA and OutB  output  WIDTH  read data.
REQ-013 The block SHALL have port Zero  output  NREG  bit k = 1 when register k is all-zeros (combinational from contents).
REQ-014 The block SHALL have port Wrap  output  NREG  bit k = sticky flag, set when register k wrapped on increment or decrement.

Function
REQ-015 On each rising Clock edge with Reset=0, every register whose RegSel bit is 0 SHALL apply FunSel; registers with RegSel bit 1 SHALL hold.
REQ-016 FunSel encoding SHALL be: 000 decrement; 001 increment; 010 load I; 011 clear to 0; 100 logical shift left, zero-fill; 101 logical shift right, zero-fill; 110 arithmetic shift right, MSB kept; 111 hold.
REQ-017 Increment and decrement SHALL be modulo 2^WIDTH: all-ones+1 -> 0 and 0-1 -> all-ones.
REQ-018 A wrapping increment or decrement on register k SHALL set Wrap[k] at the same edge the register updates.
REQ-019 ClrFlags=1 SHALL clear all Wrap bits at the edge, except that a wrap occurring in the same cycle SHALL leave its bit set (set wins).
REQ-020 Shifts SHALL never set Wrap.
REQ-021 With OUT_REG=0, OutA and OutB SHALL be the current contents of the selected register, with zero latency and no write bypass.
REQ-022 With OUT_REG=1, OutA and OutB SHALL be registered: the value at cycle n+1 equals the pre-edge contents of the register selected at cycle n (one-cycle latency, no bypass).
REQ-023 A select value >= NREG SHALL drive the corresponding read port to 0.
REQ-024 Both read ports MAY select the same register, and each SHALL return identical data.
REQ-025 Zero SHALL reflect post-edge register contents and follow them combinationally.

Reset
REQ-026 Reset=1 at a rising edge SHALL force all registers to 0, Wrap to 0, and (when OUT_REG=1) the OutA/OutB registers to 0, overriding FunSel, RegSel and ClrFlags.
REQ-027 After reset, Zero SHALL read all-ones.
REQ-028 Reset asserted mid-sequence SHALL take effect at the next edge, with no partial operation retained.

Verification (WIDTH=16, NREG=8)
REQ-029 Reset, then load: RegSel=8'b0111_1111, FunSel=010, I=16'hA5A5, one edge; OutASel=0 -> OutA=16'hA5A5, Zero=8'b1111_1110, and all other registers remain 0.
REQ-030 Wrap on increment: load register 3 with 16'hFFFF, then FunSel=001 for one edge -> register 3 = 0, Wrap[3]=1, Zero[3]=1; a further increment -> register 3 = 1, Wrap[3] stays 1.
REQ-031 Set wins over clear: register 2 = 0, FunSel=000 with ClrFlags=1 in the same cycle -> register 2 = 16'hFFFF and Wrap[2]=1; next cycle ClrFlags=1 with hold -> Wrap[2]=0.
REQ-032 Shifts: register 1 = 16'h8001; FunSel=110 -> 16'hC000; FunSel=101 -> 16'h6000; FunSel=100 -> 16'hC000; Wrap[1] stays 0.
REQ-033 OUT_REG=1 latency: register 4 = 16'h1234; OutBSel=4 at cycle n and a load of 16'h5678 at edge n -> OutB=16'h1234 at n+1 and 16'h5678 at n+2.
REQ-034 Reset mid-operation: with all registers loaded nonzero and Wrap set, assert Reset together with FunSel=001 and RegSel=0 -> all registers 0, Wrap=0, Zero=8'hFF, OutA=OutB=0.

Source files
------------

// File: rtl/reg_file_param.sv
// Parameterised register file: NREG registers of WIDTH bits, each applying a shared
// operation when enabled, with sticky wrap flags, zero flags and two read ports.
module reg_file_param #(
    parameter int WIDTH   = 16,
    parameter int NREG    = 8,
    parameter int SEL_W   = $clog2(NREG),
    parameter int OUT_REG = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [NREG-1:0]  RegSel,
    input  logic [SEL_W-1:0] OutASel,
    input  logic [SEL_W-1:0] OutBSel,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [NREG-1:0]  Zero,
    output logic [NREG-1:0]  Wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [NREG-1:0][WIDTH-1:0] regs_reg;
    logic [NREG-1:0][WIDTH-1:0] regs_next;
    logic [NREG-1:0]            wrap_reg;
    logic [NREG-1:0]            wrap_hit;
    logic [WIDTH-1:0]           rd_a;
    logic [WIDTH-1:0]           rd_b;

    // Per-register datapath; RegSel is MSB-first, so register gi owns bit NREG-1-gi.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic             en;
            logic             hit;
            logic [WIDTH-1:0] cur;
            logic [WIDTH-1:0] nxt;

            assign en  = ~RegSel[NREG-1-gi];
            assign cur = regs_reg[gi];

            always_comb begin
                nxt = cur;
                hit = 1'b0;
                if (en) begin
                    case (FunSel)
                        3'b000: begin
                            nxt = cur - ONE;
                            hit = (cur == '0);
                        end
                        3'b001: begin
                            nxt = cur + ONE;
                            hit = (cur == '1);
                        end
                        3'b010:  nxt = I;
                        3'b011:  nxt = '0;
                        3'b100:  nxt = cur << 1;
                        3'b101:  nxt = cur >> 1;
                        3'b110:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
                        default: nxt = cur;
                    endcase
                end
            end

            assign regs_next[gi] = nxt;
            assign wrap_hit[gi]  = hit;
            assign Zero[gi]      = (cur == '0);
        end
    endgenerate

    // A wrap in the same cycle as ClrFlags keeps its flag set.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            regs_reg <= '0;
            wrap_reg <= '0;
        end else begin
            regs_reg <= regs_next;
            wrap_reg <= (ClrFlags ? '0 : wrap_reg) | wrap_hit;
        end
    end

    assign Wrap = wrap_reg;

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (32'(OutASel) < NREG) rd_a = regs_reg[OutASel];
        if (32'(OutBSel) < NREG) rd_b = regs_reg[OutBSel];
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] outa_reg;
            logic [WIDTH-1:0] outb_reg;

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    outa_reg <= '0;
                    outb_reg <= '0;
                end else begin
                    outa_reg <= rd_a;
                    outb_reg <= rd_b;
                end
            end

            assign OutA = outa_reg;
            assign OutB = outb_reg;
        end else begin : g_out_comb
            assign OutA = rd_a;
            assign OutB = rd_b;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed vector table, hand sequences for latency/reset,
// out-of-range select on a 6-register instance, and random traffic against a model.
module tb_reg_file_param;

    logic        Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Reset;
    logic [15:0] I;
    logic [2:0]  FunSel;
    logic [7:0]  RegSel;
    logic [2:0]  OutASel, OutBSel;
    logic        ClrFlags;
    logic [15:0] c_outa, c_outb, r_outa, r_outb;
    logic [7:0]  c_zero, c_wrap, r_zero, r_wrap;

    logic        s_rst;
    logic [7:0]  s_i;
    logic [2:0]  s_fs;
    logic [5:0]  s_rs;
    logic [2:0]  s_asel, s_bsel;
    logic        s_clr;
    logic [7:0]  s_outa, s_outb;
    logic [5:0]  s_zero, s_wrap;

    reg_file_param #(.WIDTH(16), .NREG(8), .OUT_REG(0)) dut_c (
        .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel),
        .OutASel(OutASel), .OutBSel(OutBSel), .ClrFlags(ClrFlags),
        .OutA(c_outa), .OutB(c_outb), .Zero(c_zero), .Wrap(c_wrap));

    reg_file_param #(.WIDTH(16), .NREG(8), .OUT_REG(1)) dut_r (
        .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel),
        .OutASel(OutASel), .OutBSel(OutBSel), .ClrFlags(ClrFlags),
        .OutA(r_outa), .OutB(r_outb), .Zero(r_zero), .Wrap(r_wrap));

    reg_file_param #(.WIDTH(8), .NREG(6), .OUT_REG(0)) dut_s (
        .Clock(Clock), .Reset(s_rst), .I(s_i), .FunSel(s_fs), .RegSel(s_rs),
        .OutASel(s_asel), .OutBSel(s_bsel), .ClrFlags(s_clr),
        .OutA(s_outa), .OutB(s_outb), .Zero(s_zero), .Wrap(s_wrap));

    int tests = 0;
    int fails = 0;

    // Reference model: register values as plain integers, wrap flags as a bit vector.
    int       m [8];
    bit [7:0] mw;
    int       mra, mrb;

    typedef struct {
        logic        rst;
        logic [2:0]  fs;
        logic [7:0]  rs;
        logic [15:0] din;
        logic        clr;
        logic [2:0]  asel;
        logic [2:0]  bsel;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [7:0]  ez;
        logic [7:0]  ew;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [2:0] fs, input logic [7:0] rs,
                         input logic [15:0] din, input logic clr,
                         input logic [2:0] asel, input logic [2:0] bsel);
        Reset = rst; FunSel = fs; RegSel = rs; I = din;
        ClrFlags = clr; OutASel = asel; OutBSel = bsel;
    endtask

    task automatic model_step();
        bit [7:0] nw;
        int v, nv;
        bit hit;
        if (Reset) begin
            for (int k = 0; k < 8; k++) m[k] = 0;
            mw = '0; mra = 0; mrb = 0;
        end else begin
            mra = m[OutASel];
            mrb = m[OutBSel];
            nw = ClrFlags ? 8'h00 : mw;
            for (int k = 0; k < 8; k++) begin
                if (RegSel[7-k] == 1'b0) begin
                    v = m[k]; hit = 0;
                    case (FunSel)
                        3'd0: if (v == 0) begin nv = 65535; hit = 1; end else nv = v - 1;
                        3'd1: begin nv = (v + 1) % 65536; hit = (v + 1 == 65536); end
                        3'd2: nv = int'(I);
                        3'd3: nv = 0;
                        3'd4: nv = (v * 2) % 65536;
                        3'd5: nv = v / 2;
                        3'd6: nv = v / 2 + ((v >= 32768) ? 32768 : 0);
                        default: nv = v;
                    endcase
                    m[k] = nv;
                    if (hit) nw[k] = 1'b1;
                end
            end
            mw = nw;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    function automatic logic [7:0] model_zero();
        logic [7:0] z;
        for (int k = 0; k < 8; k++) z[k] = (m[k] == 0);
        return z;
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_c_outa"}, 32'(c_outa), 32'(m[OutASel]));
        check({tag, "_c_outb"}, 32'(c_outb), 32'(m[OutBSel]));
        check({tag, "_c_zero"}, 32'(c_zero), 32'(model_zero()));
        check({tag, "_c_wrap"}, 32'(c_wrap), 32'(mw));
        check({tag, "_r_outa"}, 32'(r_outa), 32'(mra));
        check({tag, "_r_outb"}, 32'(r_outb), 32'(mrb));
        check({tag, "_r_wrap"}, 32'(r_wrap), 32'(mw));
    endtask

    initial begin
        //           rst  fs     rs     din       clr  as    bs    ea        eb        ez     ew
        tbl[0]  = '{1'b1, 3'd7, 8'hFF, 16'h0000, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 8'hFF, 8'h00};
        tbl[1]  = '{1'b0, 3'd2, 8'h7F, 16'hA5A5, 1'b0, 3'd0, 3'd1, 16'hA5A5, 16'h0000, 8'hFE, 8'h00};
        tbl[2]  = '{1'b0, 3'd2, 8'hEF, 16'hFFFF, 1'b0, 3'd3, 3'd0, 16'hFFFF, 16'hA5A5, 8'hF6, 8'h00};
        tbl[3]  = '{1'b0, 3'd1, 8'hEF, 16'h0000, 1'b0, 3'd3, 3'd0, 16'h0000, 16'hA5A5, 8'hFE, 8'h08};
        tbl[4]  = '{1'b0, 3'd1, 8'hEF, 16'h0000, 1'b0, 3'd3, 3'd0, 16'h0001, 16'hA5A5, 8'hF6, 8'h08};
        tbl[5]  = '{1'b0, 3'd0, 8'hDF, 16'h0000, 1'b1, 3'd2, 3'd3, 16'hFFFF, 16'h0001, 8'hF2, 8'h04};
        tbl[6]  = '{1'b0, 3'd7, 8'h00, 16'h0000, 1'b1, 3'd2, 3'd3, 16'hFFFF, 16'h0001, 8'hF2, 8'h00};
        tbl[7]  = '{1'b0, 3'd2, 8'hBF, 16'h8001, 1'b0, 3'd1, 3'd1, 16'h8001, 16'h8001, 8'hF0, 8'h00};
        tbl[8]  = '{1'b0, 3'd6, 8'hBF, 16'h0000, 1'b0, 3'd1, 3'd0, 16'hC000, 16'hA5A5, 8'hF0, 8'h00};
        tbl[9]  = '{1'b0, 3'd5, 8'hBF, 16'h0000, 1'b0, 3'd1, 3'd0, 16'h6000, 16'hA5A5, 8'hF0, 8'h00};
        tbl[10] = '{1'b0, 3'd4, 8'hBF, 16'h0000, 1'b0, 3'd1, 3'd0, 16'hC000, 16'hA5A5, 8'hF0, 8'h00};
        tbl[11] = '{1'b0, 3'd4, 8'hBF, 16'h0000, 1'b0, 3'd1, 3'd0, 16'h8000, 16'hA5A5, 8'hF0, 8'h00};
        tbl[12] = '{1'b0, 3'd4, 8'hBF, 16'h0000, 1'b0, 3'd1, 3'd0, 16'h0000, 16'hA5A5, 8'hF2, 8'h00};
        tbl[13] = '{1'b0, 3'd1, 8'hFF, 16'h0000, 1'b0, 3'd0, 3'd7, 16'hA5A5, 16'h0000, 8'hF2, 8'h00};
        tbl[14] = '{1'b0, 3'd0, 8'hFE, 16'h0000, 1'b0, 3'd7, 3'd2, 16'hFFFF, 16'hFFFF, 8'h72, 8'h80};
        tbl[15] = '{1'b0, 3'd7, 8'hFF, 16'h0000, 1'b0, 3'd0, 3'd0, 16'hA5A5, 16'hA5A5, 8'h72, 8'h80};

        for (int k = 0; k < 8; k++) m[k] = 0;
        mw = '0; mra = 0; mrb = 0;
        drive(1'b1, 3'd7, 8'hFF, 16'h0, 1'b0, 3'd0, 3'd0);
        s_rst = 1'b1; s_i = 8'h00; s_fs = 3'd7; s_rs = 6'h3F;
        s_asel = 3'd0; s_bsel = 3'd0; s_clr = 1'b0;
        @(negedge Clock);

        for (int v = 0; v < NV; v++) begin
            drive(tbl[v].rst, tbl[v].fs, tbl[v].rs, tbl[v].din, tbl[v].clr,
                  tbl[v].asel, tbl[v].bsel);
            step();
            $display("[TB] vec %0d fs=%0d rs=%h a=%h b=%h zero=%h wrap=%h",
                     v, FunSel, RegSel, c_outa, c_outb, c_zero, c_wrap);
            check($sformatf("vec%0d_outa", v), 32'(c_outa), 32'(tbl[v].ea));
            check($sformatf("vec%0d_outb", v), 32'(c_outb), 32'(tbl[v].eb));
            check($sformatf("vec%0d_zero", v), 32'(c_zero), 32'(tbl[v].ez));
            check($sformatf("vec%0d_wrap", v), 32'(c_wrap), 32'(tbl[v].ew));
            check($sformatf("vec%0d_r_outa", v), 32'(r_outa), 32'(mra));
        end

        // Registered read latency: pre-edge contents appear one cycle later.
        drive(1'b0, 3'd2, 8'hF7, 16'h1234, 1'b0, 3'd0, 3'd0);
        step();
        drive(1'b0, 3'd2, 8'hF7, 16'h5678, 1'b0, 3'd0, 3'd4);
        step();
        $display("[TB] latency edge n: r_outb=%h c_outb=%h", r_outb, c_outb);
        check("lat_n_r_outb", 32'(r_outb), 32'h1234);
        check("lat_n_c_outb", 32'(c_outb), 32'h5678);
        drive(1'b0, 3'd7, 8'hFF, 16'h0000, 1'b0, 3'd0, 3'd4);
        step();
        $display("[TB] latency edge n+1: r_outb=%h", r_outb);
        check("lat_n1_r_outb", 32'(r_outb), 32'h5678);

        // Reset mid-operation with every register nonzero and every Wrap set.
        drive(1'b0, 3'd2, 8'h00, 16'hFFFF, 1'b0, 3'd0, 3'd5);
        step();
        drive(1'b0, 3'd1, 8'h00, 16'h0000, 1'b0, 3'd0, 3'd5);
        step();
        step();
        $display("[TB] pre-reset: a=%h wrap=%h zero=%h", c_outa, c_wrap, c_zero);
        check("prerst_wrap", 32'(c_wrap), 32'hFF);
        check("prerst_outa", 32'(c_outa), 32'h0001);
        drive(1'b1, 3'd1, 8'h00, 16'h0000, 1'b0, 3'd0, 3'd5);
        step();
        $display("[TB] reset: a=%h b=%h ra=%h rb=%h wrap=%h zero=%h",
                 c_outa, c_outb, r_outa, r_outb, c_wrap, c_zero);
        check("rst_zero", 32'(c_zero), 32'hFF);
        check("rst_wrap", 32'(c_wrap), 32'h00);
        check("rst_outa", 32'(c_outa), 32'h0);
        check("rst_outb", 32'(c_outb), 32'h0);
        check("rst_r_outa", 32'(r_outa), 32'h0);
        check("rst_r_outb", 32'(r_outb), 32'h0);
        check("rst_r_wrap", 32'(r_wrap), 32'h00);

        // Out-of-range selects on the 6-register instance read as zero.
        s_rst = 1'b0; s_fs = 3'd2; s_rs = 6'h00; s_i = 8'h3C;
        drive(1'b0, 3'd7, 8'hFF, 16'h0000, 1'b0, 3'd0, 3'd0);
        step();
        s_fs = 3'd7; s_asel = 3'd5; s_bsel = 3'd6;
        #1;
        $display("[TB] sel range: a(5)=%h b(6)=%h zero=%h", s_outa, s_outb, s_zero);
        check("sel5_outa", 32'(s_outa), 32'h3C);
        check("sel6_outb", 32'(s_outb), 32'h00);
        check("s_zero", 32'(s_zero), 32'h00);
        s_asel = 3'd7;
        #1;
        check("sel7_outa", 32'(s_outa), 32'h00);
        @(negedge Clock);

        for (int n = 0; n < 400; n++) begin
            logic [15:0] d;
            case ($urandom_range(0, 3))
                0:       d = 16'h0000;
                1:       d = 16'hFFFF;
                2:       d = 16'h0001;
                default: d = 16'($urandom);
            endcase
            drive(($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)), 8'($urandom),
                  d, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)));
            step();
            $display("[TB] rnd %0d rst=%0d fs=%0d rs=%h clr=%0d a=%h b=%h wrap=%h",
                     n, Reset, FunSel, RegSel, ClrFlags, c_outa, c_outb, c_wrap);
            check_model($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
